// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: gates PC advance, keeps one memory read in flight and
// buffers returned instructions in a 2-entry FIFO toward decode.
module if_fetch_buf #(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush_i,
  output logic        fetch_adv_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  count_q, count_d;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [31:0] inst_q [Depth];
  logic [31:0] pc_q   [Depth];

  logic [1:0]  occ;
  logic        accept;
  logic        push;
  logic        pop;

  // An outstanding request reserves a buffer slot so the ack can never overflow.
  assign occ    = count_q + {1'b0, (state_q != StIdle)};
  assign accept = rst_ni & ce_i & (state_q == StIdle) & (occ < 2'd2) & ~flush_i;

  assign fetch_adv_o = accept | (flush_i & rst_ni);
  assign imem_req_o  = accept;
  assign imem_addr_o = accept ? pc_i : 32'h0;

  assign id_valid_o = (count_q != 2'd0);
  assign id_inst_o  = id_valid_o ? inst_q[rptr_q] : 32'h0;
  assign id_pc_o    = id_valid_o ? pc_q[rptr_q] : 32'h0;

  assign push = (state_q == StWait) & imem_ack_i & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StWait;
          pend_pc_d = pc_i;
        end
      end
      StWait: begin
        if (imem_ack_i) begin
          state_d = StIdle;
        end else if (flush_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) begin
        wptr_d = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pend_pc_q <= 32'h0;
      count_q   <= 2'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        inst_q[i] <= 32'h0;
        pc_q[i]   <= 32'h0;
      end
    end else if (push) begin
      inst_q[wptr_q] <= imem_rdata_i;
      pc_q[wptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed cycle-by-cycle trace of the fetch buffer, plus reset-abandon and
// slow-ack sequences.
module tb_if_fetch_buf;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        ce;
  logic        flush;
  logic        fetch_adv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  int n_vec;
  int n_err;

  if_fetch_buf #(.Depth(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pc_i        (pc),
    .ce_i        (ce),
    .flush_i     (flush),
    .fetch_adv_o (fetch_adv),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_rdata_i(imem_rdata),
    .id_valid_o  (id_valid),
    .id_inst_o   (id_inst),
    .id_pc_o     (id_pc),
    .id_ready_i  (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        ce;
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_adv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [31:0] p, input logic f,
                     input logic a, input logic [31:0] d, input logic rdy,
                     input logic ea, input logic eq, input logic [31:0] ead,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v = '{r, c, p, f, a, d, rdy, ea, eq, ead, ev, ei, ep};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic got;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; ce = 1'b1; pc = 32'h100; flush = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1234; id_ready = 1'b1;

    //  rst ce pc           fl ack rdata         rdy | adv req addr     val inst          pc
    add(0, 1, 32'h100,      0, 1, 32'h1234,      1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(0, 1, 32'h100,      0, 1, 32'h1234,      1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 0, 32'h100,      0, 0, 32'h0,         1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    // single fetch
    add(1, 1, 32'h0,        0, 0, 32'h0,         1,   1, 1, 32'h0,     0, 32'h0,        32'h0);
    add(1, 1, 32'h4,        0, 1, 32'h20010005,  1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 0, 32'h4,        0, 0, 32'h0,         1,   0, 0, 32'h0,     1, 32'h20010005, 32'h0);
    // back-pressure
    add(1, 1, 32'h0,        0, 0, 32'h0,         0,   1, 1, 32'h0,     0, 32'h0,        32'h0);
    add(1, 1, 32'h4,        0, 1, 32'hA0000000,  0,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 1, 32'h4,        0, 0, 32'h0,         0,   1, 1, 32'h4,     1, 32'hA0000000, 32'h0);
    add(1, 1, 32'h8,        0, 1, 32'hA0000004,  0,   0, 0, 32'h0,     1, 32'hA0000000, 32'h0);
    add(1, 1, 32'h8,        0, 0, 32'h0,         0,   0, 0, 32'h0,     1, 32'hA0000000, 32'h0);
    add(1, 1, 32'h8,        0, 0, 32'h0,         0,   0, 0, 32'h0,     1, 32'hA0000000, 32'h0);
    add(1, 1, 32'h8,        0, 0, 32'h0,         1,   0, 0, 32'h0,     1, 32'hA0000000, 32'h0);
    add(1, 1, 32'h8,        0, 0, 32'h0,         0,   1, 1, 32'h8,     1, 32'hA0000004, 32'h4);
    // simultaneous push/pop
    add(1, 0, 32'hC,        0, 1, 32'hA0000008,  1,   0, 0, 32'h0,     1, 32'hA0000004, 32'h4);
    add(1, 0, 32'hC,        0, 0, 32'h0,         0,   0, 0, 32'h0,     1, 32'hA0000008, 32'h8);
    // flush with same-cycle ack and pop
    add(1, 1, 32'h10,       0, 0, 32'h0,         0,   1, 1, 32'h10,    1, 32'hA0000008, 32'h8);
    add(1, 1, 32'h14,       1, 1, 32'hBADBAD00,  1,   1, 0, 32'h0,     1, 32'hA0000008, 32'h8);
    add(1, 1, 32'h80,       0, 0, 32'h0,         1,   1, 1, 32'h80,    0, 32'h0,        32'h0);
    add(1, 1, 32'h84,       0, 1, 32'h11110080,  0,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    // flush during WAIT, no ack: DROP
    add(1, 1, 32'h84,       0, 0, 32'h0,         0,   1, 1, 32'h84,    1, 32'h11110080, 32'h80);
    add(1, 1, 32'h84,       1, 0, 32'h0,         0,   1, 0, 32'h0,     1, 32'h11110080, 32'h80);
    add(1, 1, 32'h40,       0, 0, 32'h0,         1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 1, 32'h40,       1, 0, 32'h0,         1,   1, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 1, 32'h40,       0, 1, 32'hDEADBEEF,  1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 1, 32'h40,       0, 0, 32'h0,         1,   1, 1, 32'h40,    0, 32'h0,        32'h0);
    add(1, 1, 32'h44,       0, 1, 32'h22220040,  1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 0, 32'h44,       0, 0, 32'h0,         1,   0, 0, 32'h0,     1, 32'h22220040, 32'h40);
    // stray ack in IDLE is ignored
    add(1, 0, 32'h44,       0, 1, 32'h33333333,  1,   0, 0, 32'h0,     0, 32'h0,        32'h0);
    add(1, 0, 32'h44,       0, 0, 32'h0,         1,   0, 0, 32'h0,     0, 32'h0,        32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; ce = vecs[i].ce; pc = vecs[i].pc; flush = vecs[i].flush;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; id_ready = vecs[i].ready;
      #2;
      chk($sformatf("v%0d.fetch_adv", i), {31'h0, fetch_adv}, {31'h0, vecs[i].e_adv});
      chk($sformatf("v%0d.imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d.id_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d.id_inst", i), id_inst, vecs[i].e_inst);
      chk($sformatf("v%0d.id_pc", i), id_pc, vecs[i].e_pc);
    end

    // Reset while a request is outstanding; the late ack must be dropped.
    @(negedge clk);
    ce = 1'b1; pc = 32'h200; flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b1;
    #2 chk("rstwait.req_before", {31'h0, imem_req}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstwait.req_in_reset", {31'h0, imem_req}, 32'h0);
    chk("rstwait.adv_in_reset", {31'h0, fetch_adv}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h55555555;
    @(negedge clk);
    imem_ack = 1'b0;
    #2;
    chk("rstwait.late_ack_valid", {31'h0, id_valid}, 32'h0);
    chk("rstwait.late_ack_inst", id_inst, 32'h0);
    ce = 1'b1; pc = 32'h300;
    #1;
    chk("rstwait.new_req", {31'h0, imem_req}, 32'h1);
    chk("rstwait.new_addr", imem_addr, 32'h300);

    // Slow memory: ack three cycles after the request, bounded wait for data.
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    chk("slow.no_req_while_wait", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h66660300;
    @(negedge clk);
    imem_ack = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (id_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("slow.valid_within_budget", {31'h0, got}, 32'h1);
    chk("slow.inst", id_inst, 32'h66660300);
    chk("slow.pc", id_pc, 32'h300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
